// File: rtl/ofm_wr_sched_pkg.sv
// Shared types and constants for the OFM write scheduler and its input FIFO.
// Holds the FSM state encoding, the beat size in bytes and the pointer-width helper.
package ofm_wr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CMD,
    DATA,
    DONE
  } state_e;

  localparam int BEAT_BYTES = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ofm_wr_sched_fifo.sv
// First-word-fall-through FIFO: head visible on pop_data with zero latency, count is registered.
// No backpressure of its own: push is dropped when full unless a pop frees the slot in the same cycle.
module ofm_wr_sched_fifo
  import ofm_wr_sched_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           pop_data,
  output logic [ptr_w(FIFO_DEPTH):0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = ptr_w(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (PTR_W+1)'(FIFO_DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/ofm_wr_sched.sv
// Buffers the OFM word stream and issues incrementing write bursts; cmd_valid follows FIFO fill by 1 cycle.
// Input cannot be stalled (excess words drop and set overflow); cmd/wr channels wait on their readies. OFM_WR_SCHED_PERF_EN adds stall_cnt.
module ofm_wr_sched
  import ofm_wr_sched_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              layer_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_word_cnt,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_last,
  output logic              busy,
  output logic              layer_done,
`ifdef OFM_WR_SCHED_PERF_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              overflow
);

  localparam int               PTR_W       = ptr_w(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  push_left_q, push_left_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  burst_l, inflight_l;
  logic              start_acc;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [PTR_W:0]    fifo_count;

  assign busy       = (state_q != IDLE);
  assign cmd_valid  = (state_q == CMD);
  assign wr_valid   = (state_q == DATA) && !fifo_empty;
  assign wr_last    = wr_valid && (beat_cnt_q == cmd_len_q);
  assign wr_data    = wr_valid ? fifo_head : '0;
  assign layer_done = (state_q == DONE);
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign overflow   = overflow_q;

  always_comb begin
    start_acc   = (state_q == IDLE) && layer_start;
    burst_l     = (rem_q > BURST_LEN_C) ? BURST_LEN_C : rem_q;
    inflight_l  = CNT_W'(cmd_len_q) + CNT_W'(1);
    fifo_push   = in_valid && busy && (push_left_q != '0) && !fifo_full;
    fifo_pop    = wr_valid && wr_ready;
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    rem_d       = rem_q;
    beat_cnt_d  = beat_cnt_q;
    push_left_d = push_left_q - CNT_W'(fifo_push);
    overflow_d  = overflow_q;
    // A word dropped in the start cycle still counts against the new layer.
    if (start_acc) overflow_d = 1'b0;
    if (in_valid && !fifo_push) overflow_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          addr_d      = cfg_base_addr;
          rem_d       = cfg_word_cnt;
          push_left_d = cfg_word_cnt;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (CNT_W'(fifo_count) >= burst_l) begin
          cmd_addr_d = addr_q;
          cmd_len_d  = 8'(burst_l - CNT_W'(1));
          state_d    = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (fifo_pop) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (wr_last) begin
            addr_d  = addr_q + ADDR_W'(inflight_l) * ADDR_W'(BEAT_BYTES);
            rem_d   = rem_q - inflight_l;
            state_d = (rem_q == inflight_l) ? DONE : WAIT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      rem_q       <= '0;
      push_left_q <= '0;
      beat_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      rem_q       <= rem_d;
      push_left_q <= push_left_d;
      beat_cnt_q  <= beat_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  ofm_wr_sched_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef OFM_WR_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if (((state_q == CMD && !cmd_ready) || (state_q == DATA && !wr_ready)) &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ofm_wr_sched.md
Name: ofm_wr_sched

Overview:
- Write scheduler between the OFM buffer's 64-bit output stream and the external-memory write port.
- Absorbs the buffer's non-stallable word stream in a small FIFO and issues fixed-length write bursts with incrementing addresses.
- Issues one shorter tail burst per layer if needed, and signals completion when the configured word count has been written.

Parameters:
- DATA_W, 64, width of an OFM word and a write beat.
- ADDR_W, 32, byte-address width.
- FIFO_DEPTH, 32, FIFO entries; power of 2 and at least BURST_LEN.
- BURST_LEN, 16, beats per full burst; at most 256.
- CNT_W, 20, width of per-layer word counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- layer_start  in  1  one-cycle pulse; latches the cfg_* inputs
- cfg_base_addr  in  ADDR_W  layer base byte address, aligned to BURST_LEN*8
- cfg_word_cnt  in  CNT_W  number of 64-bit words in the layer, greater than 0
- in_valid  in  1  OFM word present; no backpressure is possible
- in_data  in  DATA_W  OFM word
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  burst command accepted
- cmd_addr  out  ADDR_W  burst start byte address
- cmd_len  out  8  beats minus 1
- wr_valid  out  1  write beat valid
- wr_ready  in  1  write beat accepted
- wr_data  out  DATA_W  write beat
- wr_last  out  1  final beat of the burst
- busy  out  1  layer in progress
- layer_done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: an input word was dropped

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, FIFO is emptied, all counters are 0. Reset applied mid-burst abandons the burst; no partial completion is reported.
- FSM states: IDLE, WAIT, CMD, DATA, DONE.
- IDLE:
  - busy=0.
  - On layer_start: latch base into addr_q and cfg_word_cnt into rem_q and push_left_q; clear overflow; go to WAIT.
- WAIT: busy=1; compute burst length L = min(BURST_LEN, rem_q).
  - When fifo_count >= L, register cmd_addr=addr_q and cmd_len=L-1, then go to CMD.
  - cmd_valid therefore rises exactly 1 cycle after the condition is met.
- CMD:
  - cmd_valid=1; cmd_addr and cmd_len are held stable until cmd_ready.
  - On cmd_valid&cmd_ready: go to DATA with beat_cnt=0.
- DATA:
  - wr_valid=1 throughout; the FIFO already holds L words.
  - wr_data is the FIFO head, read first-word-fall-through.
  - On wr_valid&wr_ready: pop the FIFO and increment beat_cnt.
  - wr_last=1 when beat_cnt==L-1.
  - On the last handshake: addr_q+=L*8 and rem_q-=L; if rem_q becomes 0 go to DONE, else go to WAIT.
- DONE: layer_done=1 for one cycle, then go to IDLE. busy drops in the IDLE cycle.
- Input FIFO push rule: a word is pushed iff in_valid, busy, push_left_q>0 and the FIFO is not full.
  - A pushed word decrements push_left_q.
  - Otherwise in_valid drops the word and sets overflow. This covers idle, full, and excess words.
- FIFO accounting:
  - Simultaneous push and pop leaves fifo_count unchanged and is legal when full.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- layer_start while busy is ignored and does not alter the latched configuration.
- No 4 KB boundary splitting; software guarantees the base-address alignment above.
- cmd and wr channels are never both valid in the same cycle.

Optional Feature:
- Macro: OFM_WR_SCHED_PERF_EN.
- With the macro: adds output stall_cnt [31:0].
  - Increments each cycle in CMD with !cmd_ready, or in DATA with !wr_ready.
  - Saturates at 2^32-1 and clears on an accepted layer_start.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ofm_wr_sched_pkg holds:
  - the FSM state enum: IDLE, WAIT, CMD, DATA, DONE;
  - BEAT_BYTES=8;
  - the localparam log2 helpers for FIFO pointer width.
- Sub-module ofm_wr_sched_fifo: synchronous first-word-fall-through FIFO with DATA_W and FIFO_DEPTH parameters.
  - Ports: push, pop, data in/out, count, full, empty.
  - Reset is synchronous active-low.

Test Plan:
- Two full bursts: word_cnt=32, base=0x1000_0000, readies tied 1, 32 back-to-back words.
  - Expect cmds (0x1000_0000, len 15) then (0x1000_0080, len 15).
  - Expect 32 beats in input order, wr_last on beats 16 and 32, one layer_done pulse, overflow=0.
- Tail burst: word_cnt=21.
  - Expect cmds len 15 at base and len 4 at base+0x80, wr_last on beats 16 and 21, then layer_done.
- Command stall and overflow: cmd_ready held 0 for 40 cycles while 40 words arrive.
  - Expect cmd_addr and cmd_len stable and wr_valid=0.
  - Expect the FIFO to reach 32, words 33-40 dropped, overflow=1 sticky until the next layer_start.
- Data backpressure: wr_ready alternating 1/0.
  - Expect no duplicated or lost beats, data order preserved, wr_last aligned to the final accepted beat.
- Reset mid-burst: rst_n=0 during DATA.
  - Expect all outputs 0 the next cycle.
  - A subsequent layer_start with word_cnt=16 must complete normally from an empty FIFO.
- Protocol misuse: in_valid while idle, a 17th word with word_cnt=16, and layer_start while busy.
  - Expect words dropped with overflow=1, and cmd_addr unchanged by the ignored layer_start.
